// File: rtl/or_reduce_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : or_reduce_pkg
// Purpose : Shared FSM state encoding and default sizing for the
//           round-robin OR-reduction scheduler.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
package or_reduce_pkg;

  localparam int C_NREQ_DEF = 4;
  localparam int C_COLS_DEF = 16;
  localparam int C_ROWS_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;

endpackage : or_reduce_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : rr_arbiter
// Purpose : Combinational round-robin pick: first set request at or above
//           i_ptr, wrapping modulo NREQ.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [IDW-1:0]  o_grant,
  output logic            o_any
);

  localparam logic [IDW:0] C_NREQ_W = (IDW+1)'(NREQ);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IDW-1:0]    w_off;
  logic [IDW:0]      w_sum;

  // Rotate so the pointer position lands at bit 0, then find the lowest set bit
  always_comb begin
    w_dbl = {i_req, i_req} >> i_ptr;
    w_rot = w_dbl[NREQ-1:0];
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDW'(i);
    end
  end

  // Undo the rotation: pointer plus offset, wrapped back into 0..NREQ-1
  always_comb begin
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_sum >= C_NREQ_W) o_grant = IDW'(w_sum - C_NREQ_W);
    else                   o_grant = w_sum[IDW-1:0];
    o_any = |i_req;
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/or_reduce_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : or_reduce_sched
// Purpose : Shares one row-serial OR-reduction engine between NREQ matrix
//           producers; grant is held for a whole matrix, result is offered
//           on a valid/ready port with id, row count and overflow flag.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module or_reduce_sched
  import or_reduce_pkg::*;
#(
  parameter int NREQ = C_NREQ_DEF,
  parameter int COLS = C_COLS_DEF,
  parameter int ROWS = C_ROWS_DEF,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = $clog2(ROWS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ*COLS-1:0] i_req_row,
  input  logic [NREQ-1:0]      i_req_last,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [COLS-1:0]      o_out_data,
  output logic [IDW-1:0]       o_out_id,
  output logic [CNTW-1:0]      o_out_rows,
  output logic                 o_out_err
);

  localparam logic [CNTW-1:0] C_ROWS_CNT = CNTW'(ROWS);
  localparam logic [IDW-1:0]  C_LAST_ID  = IDW'(NREQ - 1);

  state_e            r_state;
  logic [COLS-1:0]   r_acc;
  logic [CNTW-1:0]   r_cnt;
  logic [IDW-1:0]    r_grant;
  logic [IDW-1:0]    r_ptr;
  logic              r_err;

  logic [IDW-1:0]    w_arb_grant;
  logic              w_any;
  logic              w_sel_valid;
  logic              w_sel_last;
  logic [COLS-1:0]   w_sel_row;
  logic              w_busy;
  logic [CNTW-1:0]   w_cnt_inc;
  logic [IDW-1:0]    w_ptr_next;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_any   (w_any)
  );

  assign w_busy     = (r_state == ST_ACCUM) || (r_state == ST_DRAIN);
  assign w_cnt_inc  = r_cnt + CNTW'(1);
  assign w_ptr_next = (r_grant == C_LAST_ID) ? '0 : r_grant + IDW'(1);

  // Select the granted requester's valid/last/row lanes
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_row   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (r_grant == IDW'(k)) begin
        w_sel_valid = i_req_valid[k];
        w_sel_last  = i_req_last[k];
        w_sel_row   = i_req_row[k*COLS +: COLS];
      end
    end
  end

  // Ready is one-hot on the grant while a matrix is streaming; decoded from registers only
  always_comb begin
    o_req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_busy && (r_grant == IDW'(k))) o_req_ready[k] = 1'b1;
    end
  end

  // Result port is a direct view of the held accumulator state
  always_comb begin
    o_out_valid = (r_state == ST_OUTPUT);
    o_out_data  = r_acc;
    o_out_id    = r_grant;
    o_out_rows  = r_cnt;
    o_out_err   = r_err;
  end

  // Arbitration, accumulation, overflow drain and result handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_ptr   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_arb_grant;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_sel_valid) begin
            r_acc <= r_acc | w_sel_row;
            r_cnt <= w_cnt_inc;
            // last wins even when this beat also fills the matrix
            if (w_sel_last) begin
              r_state <= ST_OUTPUT;
            end else if (w_cnt_inc == C_ROWS_CNT) begin
              r_err   <= 1'b1;
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // excess rows are swallowed; acc and cnt stay frozen
          if (w_sel_valid && w_sel_last) r_state <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (i_out_ready) begin
            r_ptr   <= w_ptr_next;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule : or_reduce_sched
`default_nettype wire

// File: tb/tb_or_reduce_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_or_reduce_sched
// Purpose : Directed bench for or_reduce_sched (NREQ=4, COLS=16, ROWS=16).
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_or_reduce_sched;

  localparam int NREQ = 4;
  localparam int COLS = 16;
  localparam int ROWS = 16;
  localparam int IDW  = 2;
  localparam int CNTW = 5;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*COLS-1:0] req_row;
  logic [NREQ-1:0]   req_last;
  logic              out_valid;
  logic              out_ready;
  logic [COLS-1:0]   out_data;
  logic [IDW-1:0]    out_id;
  logic [CNTW-1:0]   out_rows;
  logic              out_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        do_rst;
    logic [3:0]  valid;
    logic [63:0] row;
    logic [3:0]  last;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [15:0] e_data;
    logic [1:0]  e_id;
    logic [4:0]  e_rows;
    logic        e_err;
  } vec_t;

  vec_t tv[13];

  or_reduce_sched #(
    .NREQ (NREQ),
    .COLS (COLS),
    .ROWS (ROWS),
    .IDW  (IDW),
    .CNTW (CNTW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_row   (req_row),
    .i_req_last  (req_last),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_id    (out_id),
    .o_out_rows  (out_rows),
    .o_out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] rdy, input logic ov,
                            input logic [15:0] d, input logic [1:0] id,
                            input logic [4:0] rows, input logic err);
    chk({tag, ".req_ready"}, 64'(req_ready), 64'(rdy));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
    if (ov) begin
      chk({tag, ".out_data"}, 64'(out_data), 64'(d));
      chk({tag, ".out_id"},   64'(out_id),   64'(id));
      chk({tag, ".out_rows"}, 64'(out_rows), 64'(rows));
      chk({tag, ".out_err"},  64'(out_err),  64'(err));
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [63:0] row,
                       input logic [3:0] last, input logic ordy);
    req_valid = v;
    req_row   = row;
    req_last  = last;
    out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous assert, check all outputs zero between edges, release after posedge
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    drive(4'b0, 64'h0, 4'b0, 1'b0);
    #2;
    chk({tag, ".req_ready"}, 64'(req_ready), 64'h0);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'h0);
    chk({tag, ".out_data"},  64'(out_data),  64'h0);
    chk({tag, ".out_id"},    64'(out_id),    64'h0);
    chk({tag, ".out_rows"},  64'(out_rows),  64'h0);
    chk({tag, ".out_err"},   64'(out_err),   64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] fr [4];
    logic [15:0] r16;
    logic [3:0]  oh;
    int          k;

    rst_n = 1'b1;
    drive(4'b0, 64'h0, 4'b0, 1'b0);
    #1;
    do_reset("reset");

    // Requester 0 three-row matrix, then requesters 1 and 3 one row each
    tv[0]  = '{1'b0, 4'b0001, 64'h0000_0000_0000_0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 5'd0, 1'b0};
    tv[1]  = '{1'b0, 4'b0001, 64'h0000_0000_0000_0001, 4'b0000, 1'b1, 4'b0001, 1'b0, 16'h0000, 2'd0, 5'd0, 1'b0};
    tv[2]  = '{1'b0, 4'b0001, 64'h0000_0000_0000_0100, 4'b0000, 1'b1, 4'b0001, 1'b0, 16'h0000, 2'd0, 5'd0, 1'b0};
    tv[3]  = '{1'b0, 4'b0001, 64'h0000_0000_0000_8000, 4'b0001, 1'b1, 4'b0001, 1'b0, 16'h0000, 2'd0, 5'd0, 1'b0};
    tv[4]  = '{1'b0, 4'b0000, 64'h0,                   4'b0000, 1'b1, 4'b0000, 1'b1, 16'h8101, 2'd0, 5'd3, 1'b0};
    tv[5]  = '{1'b0, 4'b0000, 64'h0,                   4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 5'd0, 1'b0};
    tv[6]  = '{1'b1, 4'b1010, 64'h0F00_0000_00F0_0000, 4'b1010, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 5'd0, 1'b0};
    tv[7]  = '{1'b0, 4'b1010, 64'h0F00_0000_00F0_0000, 4'b1010, 1'b1, 4'b0010, 1'b0, 16'h0000, 2'd0, 5'd0, 1'b0};
    tv[8]  = '{1'b0, 4'b1000, 64'h0F00_0000_00F0_0000, 4'b1010, 1'b1, 4'b0000, 1'b1, 16'h00F0, 2'd1, 5'd1, 1'b0};
    tv[9]  = '{1'b0, 4'b1000, 64'h0F00_0000_00F0_0000, 4'b1010, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 5'd0, 1'b0};
    tv[10] = '{1'b0, 4'b1000, 64'h0F00_0000_00F0_0000, 4'b1010, 1'b1, 4'b1000, 1'b0, 16'h0000, 2'd0, 5'd0, 1'b0};
    tv[11] = '{1'b0, 4'b0000, 64'h0,                   4'b0000, 1'b1, 4'b0000, 1'b1, 16'h0F00, 2'd3, 5'd1, 1'b0};
    tv[12] = '{1'b0, 4'b0000, 64'h0,                   4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 5'd0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      if (tv[i].do_rst) do_reset($sformatf("vec%0d.rst", i));
      drive(tv[i].valid, tv[i].row, tv[i].last, tv[i].ordy);
      expect_out($sformatf("vec%0d", i), tv[i].e_rdy, tv[i].e_ov, tv[i].e_data,
                 tv[i].e_id, tv[i].e_rows, tv[i].e_err);
      step();
    end

    // Overflow: requester 2 sends 18 rows, only 16 accumulate
    do_reset("ovf.rst");
    drive(4'b0100, 64'h0, 4'b0000, 1'b1);
    expect_out("ovf.idle", 4'b0000, 1'b0, 16'h0, 2'd0, 5'd0, 1'b0);
    step();
    for (int i = 0; i < 18; i++) begin
      r16 = (i < 16) ? (16'h0001 << i) : 16'h0000;
      drive(4'b0100, {16'h0, r16, 32'h0}, (i == 17) ? 4'b0100 : 4'b0000, 1'b1);
      expect_out($sformatf("ovf.beat%0d", i), 4'b0100, 1'b0, 16'h0, 2'd0, 5'd0, 1'b0);
      step();
    end
    drive(4'b0000, 64'h0, 4'b0000, 1'b1);
    expect_out("ovf.out", 4'b0000, 1'b1, 16'hFFFF, 2'd2, 5'd16, 1'b1);
    step();
    drive(4'b0100, 64'h0000_0005_0000_0000, 4'b0100, 1'b1);
    expect_out("ovf.idle2", 4'b0000, 1'b0, 16'h0, 2'd0, 5'd0, 1'b0);
    step();
    expect_out("ovf.accum2", 4'b0100, 1'b0, 16'h0, 2'd0, 5'd0, 1'b0);
    step();
    drive(4'b0000, 64'h0, 4'b0000, 1'b1);
    expect_out("ovf.clean", 4'b0000, 1'b1, 16'h0005, 2'd2, 5'd1, 1'b0);
    step();

    // Back-pressure on the result port for 5 cycles while requester 1 waits
    do_reset("stall.rst");
    drive(4'b0011, 64'h0000_0000_1111_A5A5, 4'b0011, 1'b1);
    expect_out("stall.idle", 4'b0000, 1'b0, 16'h0, 2'd0, 5'd0, 1'b0);
    step();
    expect_out("stall.accum", 4'b0001, 1'b0, 16'h0, 2'd0, 5'd0, 1'b0);
    step();
    drive(4'b0010, 64'h0000_0000_1111_A5A5, 4'b0011, 1'b0);
    for (int i = 0; i < 5; i++) begin
      expect_out($sformatf("stall.hold%0d", i), 4'b0000, 1'b1, 16'hA5A5, 2'd0, 5'd1, 1'b0);
      step();
    end
    out_ready = 1'b1;
    expect_out("stall.release", 4'b0000, 1'b1, 16'hA5A5, 2'd0, 5'd1, 1'b0);
    step();
    expect_out("stall.idle2", 4'b0000, 1'b0, 16'h0, 2'd0, 5'd0, 1'b0);
    step();
    expect_out("stall.accum2", 4'b0010, 1'b0, 16'h0, 2'd0, 5'd0, 1'b0);
    step();
    drive(4'b0000, 64'h0, 4'b0000, 1'b1);
    expect_out("stall.out2", 4'b0000, 1'b1, 16'h1111, 2'd1, 5'd1, 1'b0);
    step();

    // Reset in the middle of a matrix, then a clean 8-row matrix
    do_reset("mid.rst0");
    drive(4'b0001, 64'h0000_0000_0000_0003, 4'b0000, 1'b1);
    expect_out("mid.idle", 4'b0000, 1'b0, 16'h0, 2'd0, 5'd0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("mid.part%0d", i), 4'b0001, 1'b0, 16'h0, 2'd0, 5'd0, 1'b0);
      step();
    end
    do_reset("mid.async");
    drive(4'b0001, 64'h0000_0000_0000_0003, 4'b0000, 1'b1);
    expect_out("mid.idle2", 4'b0000, 1'b0, 16'h0, 2'd0, 5'd0, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      drive(4'b0001, 64'h0000_0000_0000_0003, (i == 7) ? 4'b0001 : 4'b0000, 1'b1);
      expect_out($sformatf("mid.row%0d", i), 4'b0001, 1'b0, 16'h0, 2'd0, 5'd0, 1'b0);
      step();
    end
    drive(4'b0000, 64'h0, 4'b0000, 1'b1);
    expect_out("mid.out", 4'b0000, 1'b1, 16'h0003, 2'd0, 5'd8, 1'b0);
    step();

    // Fairness: all requesters always valid with 1-row matrices
    do_reset("rr.rst");
    fr[0] = 16'h0001;
    fr[1] = 16'h0020;
    fr[2] = 16'h0400;
    fr[3] = 16'h8000;
    drive(4'b1111, {fr[3], fr[2], fr[1], fr[0]}, 4'b1111, 1'b1);
    for (int n = 0; n < 6; n++) begin
      k  = n % 4;
      oh = 4'b0001 << k;
      expect_out($sformatf("rr%0d.idle", n), 4'b0000, 1'b0, 16'h0, 2'd0, 5'd0, 1'b0);
      step();
      expect_out($sformatf("rr%0d.accum", n), oh, 1'b0, 16'h0, 2'd0, 5'd0, 1'b0);
      step();
      expect_out($sformatf("rr%0d.out", n), 4'b0000, 1'b1, fr[k], 2'(k), 5'd1, 1'b0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_or_reduce_sched
`default_nettype wire
